// File: rtl/pool_pkg.sv
// Shared types and elaboration helpers for the packed 2-D pooling engine.
// The localparams describe the default configuration; instances derive their own.
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EMIT,
    S_WRITE,
    S_DONE
  } pool_state_e;

  function automatic int clog2_c(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : clog2_c(n);
  endfunction

  function automatic int out_dim(input int in_dim, input int k, input int s);
    return (in_dim - k) / s + 1;
  endfunction

  localparam int PACK    = 32 / 4;
  localparam int OUT_H   = out_dim(8, 2, 2);
  localparam int OUT_W   = out_dim(8, 2, 2);
  localparam int N_OUT   = 128 * OUT_H * OUT_W;
  localparam int N_WORDS = (N_OUT + PACK - 1) / PACK;

endpackage

// File: rtl/pool_window_reduce.sv
// Window fold unit: running unsigned max or running sum, one datum per vld.
// result already includes the datum presented this cycle.
module pool_window_reduce
  import pool_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int KK     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              vld,
  input  pool_mode_e        mode,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] result
);

  localparam int LOG_KK = clog2_c(KK);
  // Averaging is only built when the window size divides by a shift;
  // otherwise an average request folds as max.
  localparam bit AVG_OK = ((1 << LOG_KK) == KK);
  localparam int ACC_W  = DATA_W + LOG_KK;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] din_ext;
  logic [ACC_W-1:0] fold;
  logic [ACC_W-1:0] cur;
  logic             avg;

  always_comb begin
    avg     = (mode == POOL_AVG) && AVG_OK;
    din_ext = ACC_W'(din);
    fold    = acc;
    if (clr)                fold = din_ext;
    else if (avg)           fold = acc + din_ext;
    else if (din_ext > acc) fold = din_ext;
    cur    = vld ? fold : acc;
    result = avg ? DATA_W'(cur >> LOG_KK) : DATA_W'(cur);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    acc <= '0;
    else if (vld) acc <= fold;
  end

endmodule

// File: rtl/pool2d_packed_engine.sv
// Pooling engine top: window walker FSM, source address generation and
// lane packer writing PACK results per 32-bit destination word.
module pool2d_packed_engine
  import pool_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CH     = 128,
  parameter int IN_H   = 8,
  parameter int IN_W   = 8,
  parameter int K      = 2,
  parameter int S      = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] src_addr,
  output logic              src_en,
  input  logic [DATA_W-1:0] src_data,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [31:0]       dst_din,
  output logic              dst_we
);

  localparam int LANES  = 32 / DATA_W;
  localparam int OH     = out_dim(IN_H, K, S);
  localparam int OW     = out_dim(IN_W, K, S);
  localparam int NOUT   = CH * OH * OW;
  localparam int NWORDS = (NOUT + LANES - 1) / LANES;
  localparam int CH_W   = cnt_w(CH);
  localparam int OH_W   = cnt_w(OH);
  localparam int OW_W   = cnt_w(OW);
  localparam int K_W    = cnt_w(K);
  localparam int LANE_W = cnt_w(LANES);
  localparam int WORD_W = cnt_w(NWORDS);

  if (32 % DATA_W != 0) begin : g_bad_data_w
    $error("DATA_W must divide 32");
  end
  if (K > IN_H || K > IN_W || K < 1 || S < 1) begin : g_bad_kernel
    $error("kernel must fit the input and stride must be positive");
  end
  if (ADDR_W < clog2_c(CH * IN_H * IN_W)) begin : g_bad_addr_w
    $error("ADDR_W too narrow for the source map");
  end

  pool_state_e       state;
  pool_mode_e        mode_q;
  logic              armed;
  logic [CH_W-1:0]   ch, nxt_ch;
  logic [OH_W-1:0]   orow, nxt_orow;
  logic [OW_W-1:0]   ocol, nxt_ocol;
  logic [K_W-1:0]    tap_r, tap_c, nxt_tr, nxt_tc;
  logic [LANE_W-1:0] lane;
  logic [WORD_W-1:0] word_idx;
  logic [31:0]       pack, pack_ins;
  logic              fold_vld, fold_first;
  logic              last_tap, last_out;
  logic [DATA_W-1:0] win_result;

  pool_window_reduce #(.DATA_W(DATA_W), .KK(K * K)) u_reduce (
    .clk    (clk),
    .reset  (reset),
    .clr    (fold_first),
    .vld    (fold_vld),
    .mode   (mode_q),
    .din    (src_data),
    .result (win_result)
  );

  function automatic logic [ADDR_W-1:0] elem_addr(
    input logic [CH_W-1:0] c, input logic [OH_W-1:0] r, input logic [OW_W-1:0] q,
    input logic [K_W-1:0] tr, input logic [K_W-1:0] tc);
    return ADDR_W'(c) * ADDR_W'(IN_H * IN_W)
         + (ADDR_W'(r) * ADDR_W'(S) + ADDR_W'(tr)) * ADDR_W'(IN_W)
         + ADDR_W'(q) * ADDR_W'(S) + ADDR_W'(tc);
  endfunction

  always_comb begin
    last_tap = (tap_r == K_W'(K - 1)) && (tap_c == K_W'(K - 1));
    nxt_tc   = (tap_c == K_W'(K - 1)) ? '0 : tap_c + 1'b1;
    nxt_tr   = (tap_c == K_W'(K - 1)) ? tap_r + 1'b1 : tap_r;
    nxt_ocol = ocol;
    nxt_orow = orow;
    nxt_ch   = ch;
    // ocol runs fastest, then orow, then ch.
    if (ocol == OW_W'(OW - 1)) begin
      nxt_ocol = '0;
      if (orow == OH_W'(OH - 1)) begin
        nxt_orow = '0;
        nxt_ch   = ch + 1'b1;
      end else begin
        nxt_orow = orow + 1'b1;
      end
    end else begin
      nxt_ocol = ocol + 1'b1;
    end
    last_out = (ch == CH_W'(CH - 1)) && (orow == OH_W'(OH - 1)) && (ocol == OW_W'(OW - 1));
    pack_ins = pack | (32'(win_result) << (DATA_W * (LANES - 1 - int'(lane))));
  end

  // NOTE: every output is a register loaded on the edge that enters the state
  // it belongs to, so the strobes line up with their state with no glue logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      mode_q     <= POOL_MAX;
      armed      <= 1'b0;
      ch         <= '0;
      orow       <= '0;
      ocol       <= '0;
      tap_r      <= '0;
      tap_c      <= '0;
      lane       <= '0;
      word_idx   <= '0;
      pack       <= '0;
      fold_vld   <= 1'b0;
      fold_first <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      src_en     <= 1'b0;
      src_addr   <= '0;
      dst_we     <= 1'b0;
      dst_addr   <= '0;
      dst_din    <= '0;
    end else begin
      armed      <= 1'b1;
      done       <= 1'b0;
      dst_we     <= 1'b0;
      fold_vld   <= (state == S_FETCH);
      fold_first <= (state == S_FETCH) && (tap_r == '0) && (tap_c == '0);
      unique case (state)
        S_IDLE: begin
          // armed blocks a start on the first edge after reset release.
          if (start && armed) begin
            mode_q   <= pool_mode_e'(mode);
            ch       <= '0;
            orow     <= '0;
            ocol     <= '0;
            tap_r    <= '0;
            tap_c    <= '0;
            lane     <= '0;
            word_idx <= '0;
            pack     <= '0;
            busy     <= 1'b1;
            src_en   <= 1'b1;
            src_addr <= '0;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (last_tap) begin
            tap_r  <= '0;
            tap_c  <= '0;
            src_en <= 1'b0;
            state  <= S_EMIT;
          end else begin
            tap_r    <= nxt_tr;
            tap_c    <= nxt_tc;
            src_addr <= elem_addr(ch, orow, ocol, nxt_tr, nxt_tc);
          end
        end
        S_EMIT: begin
          pack <= pack_ins;
          if (lane == LANE_W'(LANES - 1) || last_out) begin
            dst_we   <= 1'b1;
            dst_addr <= ADDR_W'(word_idx);
            dst_din  <= pack_ins;
            state    <= S_WRITE;
          end else begin
            lane     <= lane + 1'b1;
            ch       <= nxt_ch;
            orow     <= nxt_orow;
            ocol     <= nxt_ocol;
            src_en   <= 1'b1;
            src_addr <= elem_addr(nxt_ch, nxt_orow, nxt_ocol, '0, '0);
            state    <= S_FETCH;
          end
        end
        S_WRITE: begin
          pack     <= '0;
          lane     <= '0;
          word_idx <= word_idx + 1'b1;
          if (last_out) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            ch       <= nxt_ch;
            orow     <= nxt_orow;
            ocol     <= nxt_ocol;
            src_en   <= 1'b1;
            src_addr <= elem_addr(nxt_ch, nxt_orow, nxt_ocol, '0, '0);
            state    <= S_FETCH;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
